collision_detector: RTL and testbench

COLLISION_DETECTOR -- requirements
Module: collision_detector

---
 rtl/collision_detector.sv | 189 ++++++++++++++++++
 tb/tb_collision_detector.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/collision_detector.sv
// ---------------------------------------------------------------------------
// collision_detector
//
// Judges one snake move. A step pulse latches the new head, the apple and the
// body length. The checker then tests the head against the arena border and
// the apple, and walks the body RAM (segments 1 .. length-1) looking for a
// self-hit. One REPORT cycle pulses done together with goodColl or badColl
// (never both) and the FSM returns to IDLE.
//
// Body RAM handshake: segRd/segAddr are driven combinationally from the
// current state, so the RAM captures the request on the next rising edge and
// presents segX/segY during the following cycle. That is the cycle in which
// SCAN compares the segment and, if needed, requests the next one.
//
// Latency from the accepting edge E0 to the REPORT cycle:
//   wall hit or length <= 1 : 1
//   self-hit at segment i   : i + 1
//   otherwise               : length (clamped to MAX_LEN)
//
// Build option: define COLL_WALL_WRAP_EN for a wrap-around arena in which
// border cells are legal (the wall term is forced to 0).
// ---------------------------------------------------------------------------
module collision_detector #(
   parameter int MAX_LEN    = 100,
   parameter int GRID_X_MAX = 15,
   parameter int GRID_Y_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       step,
   input  logic [3:0] headX,
   input  logic [3:0] headY,
   input  logic [3:0] appleX,
   input  logic [3:0] appleY,
   input  logic [6:0] bodyLen,
   output logic [6:0] segAddr,
   output logic       segRd,
   input  logic [3:0] segX,
   input  logic [3:0] segY,
   output logic       goodColl,
   output logic       badColl,
   output logic       done,
   output logic       busy
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] CHECK  = 2'd1;
   localparam logic [1:0] SCAN   = 2'd2;
   localparam logic [1:0] REPORT = 2'd3;

   localparam logic [6:0] MAX_LEN_C = 7'(MAX_LEN);
   localparam logic [3:0] X_MAX_C   = 4'(GRID_X_MAX);
   localparam logic [3:0] Y_MAX_C   = 4'(GRID_Y_MAX);

   logic [1:0] state_q,   state_d;
   logic [3:0] head_x_q,  head_x_d;
   logic [3:0] head_y_q,  head_y_d;
   logic [3:0] apple_x_q, apple_x_d;
   logic [3:0] apple_y_q, apple_y_d;
   logic [6:0] len_q,     len_d;
   logic [6:0] idx_q,     idx_d;
   logic       self_q,    self_d;

   logic       wall;
   logic       apple_hit;
   logic       seg_hit;
   logic       short_body;
   logic       last_seg;
   logic [6:0] len_clamped;
   logic       seg_rd;
   logic [6:0] seg_addr;

   // Classify the latched head: border cell, apple cell, short body.
   always_comb begin
`ifdef COLL_WALL_WRAP_EN
      wall = 1'b0;
`else
      wall = (head_x_q == 4'd0) || (head_x_q == X_MAX_C) ||
             (head_y_q == 4'd0) || (head_y_q == Y_MAX_C);
`endif
      apple_hit   = (head_x_q == apple_x_q) && (head_y_q == apple_y_q);
      seg_hit     = (segX == head_x_q) && (segY == head_y_q);
      short_body  = (len_q <= 7'd1);
      last_seg    = (idx_q >= (len_q - 7'd1));
      len_clamped = (bodyLen > MAX_LEN_C) ? MAX_LEN_C : bodyLen;
   end

   // Next-state, body-RAM request and operand latching.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path
      // leaves one unassigned; that is what keeps this block latch-free.
      state_d   = state_q;
      head_x_d  = head_x_q;
      head_y_d  = head_y_q;
      apple_x_d = apple_x_q;
      apple_y_d = apple_y_q;
      len_d     = len_q;
      idx_d     = idx_q;
      self_d    = self_q;
      seg_rd    = 1'b0;
      seg_addr  = 7'd0;

      case (state_q)
         IDLE: begin
            if (step) begin
               head_x_d  = headX;
               head_y_d  = headY;
               apple_x_d = appleX;
               apple_y_d = appleY;
               len_d     = len_clamped;
               idx_d     = 7'd0;
               self_d    = 1'b0;
               state_d   = CHECK;
            end
         end

         CHECK: begin
            if (wall || short_body) begin
               state_d = REPORT;
            end else begin
               seg_rd   = 1'b1;
               seg_addr = 7'd1;
               idx_d    = 7'd1;
               state_d  = SCAN;
            end
         end

         SCAN: begin
            // segX/segY hold segment idx_q during this cycle.
            if (seg_hit) begin
               self_d  = 1'b1;
               state_d = REPORT;
            end else if (last_seg) begin
               state_d = REPORT;
            end else begin
               seg_rd   = 1'b1;
               seg_addr = idx_q + 7'd1;
               idx_d    = idx_q + 7'd1;
            end
         end

         REPORT: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and operand registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples its _d value from before this edge.
      if (rst) begin
         // NOTE: the operand registers are reset as well; they are few and
         // this keeps every output and debug view deterministic after reset.
         state_q   <= IDLE;
         head_x_q  <= 4'd0;
         head_y_q  <= 4'd0;
         apple_x_q <= 4'd0;
         apple_y_q <= 4'd0;
         len_q     <= 7'd0;
         idx_q     <= 7'd0;
         self_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         head_x_q  <= head_x_d;
         head_y_q  <= head_y_d;
         apple_x_q <= apple_x_d;
         apple_y_q <= apple_y_d;
         len_q     <= len_d;
         idx_q     <= idx_d;
         self_q    <= self_d;
      end
   end

   // Result pulses live only in REPORT; bad always wins over good.
   always_comb begin
      done     = (state_q == REPORT);
      badColl  = done && (wall || self_q);
      goodColl = done && apple_hit && !(wall || self_q);
      busy     = (state_q != IDLE);
      segRd    = seg_rd;
      segAddr  = seg_addr;
   end

endmodule

// File: tb/tb_collision_detector.sv
// ---------------------------------------------------------------------------
// tb_collision_detector
//
// Directed bench for collision_detector (default build, wall enabled).
// A behavioural body RAM answers segRd one cycle later. Each accepted step
// pushes its expected latency/result onto a scoreboard queue; the entry is
// popped and compared when done appears.
// ---------------------------------------------------------------------------
module tb_collision_detector;

   typedef struct {
      int   lat;
      logic good;
      logic bad;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       step;
   logic [3:0] headX, headY, appleX, appleY;
   logic [6:0] bodyLen;
   logic [6:0] segAddr;
   logic       segRd;
   logic [3:0] segX, segY;
   logic       goodColl, badColl, done, busy;

   int checks   = 0;
   int failures = 0;
   int done_cnt = 0;
   int coll_cnt = 0;

   exp_t       sb[$];
   logic [6:0] rd_log[$];

   logic [3:0] mem_x[128];
   logic [3:0] mem_y[128];
   logic       req_v = 1'b0;
   logic [6:0] req_a = 7'd0;

   collision_detector dut (
      .clk      (clk),
      .rst      (rst),
      .step     (step),
      .headX    (headX),
      .headY    (headY),
      .appleX   (appleX),
      .appleY   (appleY),
      .bodyLen  (bodyLen),
      .segAddr  (segAddr),
      .segRd    (segRd),
      .segX     (segX),
      .segY     (segY),
      .goodColl (goodColl),
      .badColl  (badColl),
      .done     (done),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture the read request mid-cycle, answer it on the next rising edge.
   always @(negedge clk) begin
      req_v = segRd;
      req_a = segAddr;
      if (segRd) rd_log.push_back(segAddr);
      if (done) done_cnt++;
      if (goodColl || badColl) coll_cnt++;
   end

   always @(posedge clk) begin
      if (req_v) begin
         segX <= mem_x[req_a];
         segY <= mem_y[req_a];
      end
   end

   // Good and bad must never pulse together.
   always @(negedge clk) begin
      if (done) begin
         checks++;
         assert (!(goodColl && badColl)) else begin
            failures++;
            $error("FAIL exclusive: observed good=%0b bad=%0b expected not both", goodColl, badColl);
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Body filled with a cell that no test head ever occupies.
   task automatic fill_body();
      for (int i = 0; i < 128; i++) begin
         mem_x[i] = 4'd2;
         mem_y[i] = 4'd9;
      end
   endtask

   // One complete check: accept a step, wait for done, score the result.
   task automatic run_check(input string tag,
                            input logic [3:0] hx, input logic [3:0] hy,
                            input logic [3:0] ax, input logic [3:0] ay,
                            input logic [6:0] len, input int exp_lat,
                            input logic eg, input logic eb, input int nrd);
      exp_t e;
      exp_t got;
      int   k;
      int   bad_addr;
      headX   = hx;
      headY   = hy;
      appleX  = ax;
      appleY  = ay;
      bodyLen = len;
      step    = 1'b1;
      rd_log.delete();
      tick();                       // E0
      step  = 1'b0;
      e.lat  = exp_lat;
      e.good = eg;
      e.bad  = eb;
      sb.push_back(e);
      k = 0;
      while (k < 300 && !done) begin
         tick();
         k++;
      end
      check({tag, ".done"}, {31'd0, done}, 32'd1);
      got = sb.pop_front();
      check({tag, ".latency"}, k, got.lat);
      check({tag, ".good"}, {31'd0, goodColl}, {31'd0, got.good});
      check({tag, ".bad"}, {31'd0, badColl}, {31'd0, got.bad});
      check({tag, ".nreads"}, rd_log.size(), nrd);
      bad_addr = 0;
      for (int i = 0; i < rd_log.size(); i++)
         if (rd_log[i] !== 7'(i + 1)) bad_addr++;
      check({tag, ".addrs"}, bad_addr, 0);
      tick();
      check({tag, ".idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      int   k;
      int   d0;
      int   c0;
      exp_t e;
      exp_t got;

      rst     = 1'b1;
      step    = 1'b1;
      headX   = 4'd5;
      headY   = 4'd5;
      appleX  = 4'd5;
      appleY  = 4'd5;
      bodyLen = 7'd3;
      segX    = 4'd0;
      segY    = 4'd0;
      fill_body();

      // Reset held two cycles with step asserted: outputs quiet, step ignored.
      tick();
      tick();
      check("reset.outputs", {22'd0, goodColl, badColl, done, busy, segRd, segAddr}, 32'd0);
      rst  = 1'b0;
      step = 1'b0;
      tick();
      check("reset.step_ignored", {31'd0, busy}, 32'd0);
      tick();

      // Apple eaten after a clean two-segment scan.
      fill_body();
      mem_x[1] = 4'd5; mem_y[1] = 4'd4;
      mem_x[2] = 4'd5; mem_y[2] = 4'd3;
      run_check("apple", 4'd5, 4'd5, 4'd5, 4'd5, 7'd3, 3, 1'b1, 1'b0, 2);

      // Self-hit at segment 2 while on the apple: bad wins, reads stop.
      fill_body();
      mem_x[1] = 4'd7; mem_y[1] = 4'd6;
      mem_x[2] = 4'd7; mem_y[2] = 4'd7;
      mem_x[3] = 4'd7; mem_y[3] = 4'd7;
      run_check("self_apple", 4'd7, 4'd7, 4'd7, 4'd7, 7'd6, 3, 1'b0, 1'b1, 2);

      // Border cells: left, right, bottom, and a corner that is also the apple.
      fill_body();
      run_check("wall_left",   4'd0,  4'd4,  4'd9, 4'd9, 7'd4, 1, 1'b0, 1'b1, 0);
      run_check("wall_right",  4'd15, 4'd5,  4'd9, 4'd9, 7'd4, 1, 1'b0, 1'b1, 0);
      run_check("wall_bottom", 4'd6,  4'd15, 4'd9, 4'd9, 7'd4, 1, 1'b0, 1'b1, 0);
      run_check("wall_apple",  4'd0,  4'd0,  4'd0, 4'd0, 7'd5, 1, 1'b0, 1'b1, 0);

      // Short bodies skip the scan.
      run_check("len1",       4'd3, 4'd3, 4'd9, 4'd9, 7'd1, 1, 1'b0, 1'b0, 0);
      run_check("len1_apple", 4'd4, 4'd4, 4'd4, 4'd4, 7'd1, 1, 1'b1, 1'b0, 0);
      run_check("len0",       4'd4, 4'd4, 4'd9, 4'd9, 7'd0, 1, 1'b0, 1'b0, 0);

      // Clean move, full scan.
      run_check("clear", 4'd6, 4'd10, 4'd2, 4'd2, 7'd4, 4, 1'b0, 1'b0, 3);

      // Self-hit on the very last segment.
      fill_body();
      mem_x[4] = 4'd6; mem_y[4] = 4'd6;
      run_check("self_last", 4'd6, 4'd6, 4'd2, 4'd2, 7'd5, 5, 1'b0, 1'b1, 4);

      // Length above MAX_LEN is clamped to 100.
      fill_body();
      run_check("clamp", 4'd6, 4'd10, 4'd2, 4'd2, 7'd127, 100, 1'b0, 1'b0, 99);

      // Overlapping step at E0+2 plus a bodyLen change: current check unaffected.
      fill_body();
      d0      = done_cnt;
      headX   = 4'd8;  headY  = 4'd8;
      appleX  = 4'd1;  appleY = 4'd1;
      bodyLen = 7'd10;
      step    = 1'b1;
      tick();                       // E0
      step = 1'b0;
      e.lat = 10; e.good = 1'b0; e.bad = 1'b0;
      sb.push_back(e);
      tick();                       // E1
      step    = 1'b1;
      headX   = 4'd5;  headY  = 4'd5;
      appleX  = 4'd5;  appleY = 4'd5;
      bodyLen = 7'd3;
      tick();                       // E2: step seen while busy
      step = 1'b0;
      k = 2;
      while (k < 300 && !done) begin
         tick();
         k++;
      end
      check("overlap.done", {31'd0, done}, 32'd1);
      got = sb.pop_front();
      check("overlap.latency", k, got.lat);
      check("overlap.good", {31'd0, goodColl}, {31'd0, got.good});
      check("overlap.bad", {31'd0, badColl}, {31'd0, got.bad});
      for (int i = 0; i < 6; i++) tick();
      check("overlap.one_done", done_cnt - d0, 1);
      check("overlap.idle", {31'd0, busy}, 32'd0);

      // Reset at E0+3 mid-scan: no result pulses, idle straight away.
      d0      = done_cnt;
      c0      = coll_cnt;
      headX   = 4'd7;  headY  = 4'd7;
      appleX  = 4'd7;  appleY = 4'd7;
      bodyLen = 7'd10;
      step    = 1'b1;
      tick();                       // E0
      step = 1'b0;
      tick();                       // E1
      tick();                       // E2
      rst = 1'b1;
      tick();                       // E3
      rst = 1'b0;
      check("abort.outputs", {22'd0, goodColl, badColl, done, busy, segRd, segAddr}, 32'd0);
      for (int i = 0; i < 15; i++) tick();
      check("abort.no_done", done_cnt - d0, 0);
      check("abort.no_coll", coll_cnt - c0, 0);

      // Normal operation resumes after the abort.
      fill_body();
      mem_x[1] = 4'd5; mem_y[1] = 4'd4;
      mem_x[2] = 4'd5; mem_y[2] = 4'd3;
      run_check("resume", 4'd5, 4'd5, 4'd5, 4'd5, 7'd3, 3, 1'b1, 1'b0, 2);

      check("scoreboard.empty", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
